multi_clk_divider: RTL and testbench
====================================

# multi_clk_divider

Parametrised, multi-channel successor to the fixed-ratio toggle divider. Each of `NUM_CH` channels derives a divided clock from `clk_in`. Per channel, the period and high time are programmable at runtime, and a one-cycle `tick` strobe marks each period start. Configuration changes are glitch-free and take effect only at a period boundary. A global `sync` input phase-aligns all running channels. The block sits between the system clock and slow protocol logic (bit-rate enables, sampling strobes).

## Interface
- `NUM_CH`, default 4: number of independent channels.
- `DIV_W`, default 16: width of the period and high-time counters and config fields.
- `DEFAULT_DIV`, default 100: per-channel period N loaded at reset. Must be ≥2 and <2^DIV_W.
- `DEFAULT_HIGH`, default 50: per-channel high time H loaded at reset. Must satisfy 1 ≤ H < DEFAULT_DIV.
- `clk_in`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  NUM_CH  per-channel run enable.
- `sync`  in  1  global phase-align pulse.
- `cfg_wr`  in  1  config write strobe.
- `cfg_ch`  in  max(1,clog2(NUM_CH))  target channel; writes to values ≥NUM_CH are ignored.
- `cfg_div`  in  DIV_W  requested period N, in clk_in cycles.
- `cfg_high`  in  DIV_W  requested high time H, in clk_in cycles.
- `cfg_pending`  out  NUM_CH  write accepted but not yet applied.
- `clk_out`  out  NUM_CH  divided clock, registered.
- `tick`  out  NUM_CH  one-cycle period-start strobe, registered.

## Operation
- **Per-channel state:** `cnt` (DIV_W), `run`, active N/H, and pending N/H/valid.
- **Clamping** is applied when a config is written to pending:
  - N<2 → 2.
  - H=0 → 1.
  - H≥N → N−1, using the clamped N.
- **Next-count rule**, evaluated at each rising edge per channel, in priority order:
  - en=0: run←0, cnt←0, clk_out←0, tick←0.
  - en=1 and (run=0, or sync=1, or cnt==N−1): **period start**. run←1, cnt←0, clk_out←1, tick←1.
  - otherwise: cnt←cnt+1, clk_out←(cnt+1 < H), tick←0.
- **Config write** (cfg_wr=1, cfg_ch valid): the clamped N/H go into the pending registers and pending valid←1. A later write before apply overwrites the pending value; last write wins.
- **Config apply:**
  - At any period-start edge, or any edge where the channel ends with run=0, a valid pending config becomes active and pending valid clears.
  - The new N/H govern the period beginning at that edge.
  - A write coinciding with an apply edge bypasses pending: its data is applied at that edge and `cfg_pending` stays 0.
- **sync** only affects running channels (en=1); disabled channels ignore it.
- Resulting waveform: clk_out is high for exactly H cycles and low for N−H cycles. Periods are never truncated or stretched except by `sync` or by `en` falling.

## Timing
- **Reset** (async assert, sync-safe release): cnt=0, run=0, clk_out=0, tick=0, cfg_pending=0, active N=DEFAULT_DIV, H=DEFAULT_HIGH.
- **Enable latency:** en sampled 1 at edge k → clk_out=1 and tick=1 in cycle k+1. tick then repeats every N cycles.
- **Disable latency:** en sampled 0 at edge k → clk_out=0 from cycle k+1. There is no completion of the current period.
- **Config latency:** the write is visible on `cfg_pending` the cycle after the strobe. It is applied at the next period start, at most N_old cycles later.
- **sync:** sampled at edge k → every running channel shows tick=1 and clk_out=1 in cycle k+1.
- **Simultaneous sync and natural wrap:** a single period start, no double tick.
- **Simultaneous en falling and cfg_wr:** the channel stops, and the config is applied at that edge.
- **Counter arithmetic:** unsigned, DIV_W bits. cnt never exceeds N−1, so there is no overflow. N=2^DIV_W−1 is the maximum period.
- **Reset mid-period:** outputs drop immediately (asynchronous); pending config is discarded.

## Test plan
- **Reset defaults:** reset, en[0]=1 → tick[0] on cycles 1, 101, 201; clk_out[0] high 50 cycles, low 50 cycles.
- **Clamp:** write ch1 N=1, H=0 while en[1]=0, then enable → clk_out[1] alternates 1,0 and tick[1] every 2 cycles. Write N=5, H=9 → H=4: high 4 cycles, low 1 cycle.
- **Glitch-free reconfig:** ch0 running N=100; at cnt=30 write N=10, H=3 → cfg_pending[0]=1 for 70 cycles. The old period completes unchanged, then 3 cycles high / 7 low.
- **Bypass:** a write coinciding with the wrap edge → new N/H used immediately and cfg_pending never asserts.
- **Sync align:** ch0 N=7, ch1 N=11 at arbitrary phases; pulse sync → both tick on the same cycle and realign. A disabled ch2 stays low.
- **Mid-operation:** drop en at cnt=20 → clk_out low next cycle; re-enable → fresh full period. Assert rst at cnt=40 → all outputs 0 immediately and the pending config is lost. An invalid cfg_ch=NUM_CH write changes nothing.

Source files
------------

// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider: per-channel period/high-time,
// period-start tick, glitch-free reconfiguration at period boundaries, global sync.
module multi_clk_divider #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 100,
  parameter int DEFAULT_HIGH = 50,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [DIV_W-1:0] clamp_div;
  logic [DIV_W-1:0] clamp_high;

  // High time is clamped against the already-clamped period so H < N always holds.
  always_comb begin
    clamp_div  = cfg_div;
    clamp_high = cfg_high;
    if (cfg_div < DIV_W'(2))
      clamp_div = DIV_W'(2);
    if (cfg_high == '0)
      clamp_high = DIV_W'(1);
    if (clamp_high >= clamp_div)
      clamp_high = clamp_div - DIV_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_n;
    logic [DIV_W-1:0] act_h;
    logic [DIV_W-1:0] pend_n;
    logic [DIV_W-1:0] pend_h;
    logic             pend_v;
    logic             run;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             start;
    logic             apply;

    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));
    assign start  = en[i] && (!run || sync || (cnt == act_n - DIV_W'(1)));
    // A stopped channel has no period in flight, so every disabled edge is a safe apply point.
    assign apply  = start || !en[i];

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        run    <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        act_n  <= DIV_W'(DEFAULT_DIV);
        act_h  <= DIV_W'(DEFAULT_HIGH);
        pend_n <= '0;
        pend_h <= '0;
        pend_v <= 1'b0;
      end else begin
        if (!en[i]) begin
          run    <= 1'b0;
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (start) begin
          run    <= 1'b1;
          cnt    <= '0;
          clk_q  <= 1'b1;
          tick_q <= 1'b1;
        end else begin
          cnt    <= cnt + DIV_W'(1);
          clk_q  <= (cnt + DIV_W'(1)) < act_h;
          tick_q <= 1'b0;
        end

        // A write landing on an apply edge bypasses the pending registers.
        if (apply) begin
          if (wr_hit) begin
            act_n <= clamp_div;
            act_h <= clamp_high;
          end else if (pend_v) begin
            act_n <= pend_n;
            act_h <= pend_h;
          end
          pend_v <= 1'b0;
        end else if (wr_hit) begin
          pend_n <= clamp_div;
          pend_h <= clamp_high;
          pend_v <= 1'b1;
        end
      end
    end

    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
    assign cfg_pending[i] = pend_v;
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Scoreboard bench for multi_clk_divider: directed stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_multi_clk_divider;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;

  logic              clk_in;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_wr;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] cfg_pending;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  multi_clk_divider #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(100),
    .DEFAULT_HIGH(50)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .sync(sync),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .cfg_pending(cfg_pending),
    .clk_out(clk_out),
    .tick(tick)
  );

  typedef struct {
    int   cyc;
    int   ch;
    int   kind;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e);
    logic  act;
    string nm;
    n_tests++;
    case (e.kind)
      0:       begin act = clk_out[e.ch];     nm = "clk_out";     end
      1:       begin act = tick[e.ch];        nm = "tick";        end
      default: begin act = cfg_pending[e.ch]; nm = "cfg_pending"; end
    endcase
    if (e.cyc < cyc) begin
      n_fail++;
      $display("[TB] FAIL stale_%s ch%0d: expectation for cycle %0d checked at cycle %0d", nm, e.ch, e.cyc, cyc);
    end else if (act !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s ch%0d cycle %0d: got %b, expected %b", nm, e.ch, cyc, act, e.val);
    end
  endtask

  // Monitor: every cycle, retire all expectations that are due.
  always @(negedge clk_in) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int ch, input int kind, input logic v);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expectWave(input int ch, input int first, input int n, input int h, input int len);
    for (int j = 0; j < len; j++) begin
      push(first + j, ch, 0, (j % n) < h);
      push(first + j, ch, 1, (j % n) == 0);
    end
  endtask

  task automatic expectLow(input int ch, input int first, input int len);
    for (int j = 0; j < len; j++) begin
      push(first + j, ch, 0, 1'b0);
      push(first + j, ch, 1, 1'b0);
    end
  endtask

  task automatic expectPend(input int ch, input int first, input int len, input logic v);
    for (int j = 0; j < len; j++)
      push(first + j, ch, 2, v);
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] ch, input int dv, input int hi);
    cfg_wr   = wr;
    cfg_ch   = ch;
    cfg_div  = DIV_W'(dv);
    cfg_high = DIV_W'(hi);
  endtask

  task automatic advanceTo(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  int t, s1, p, c0, e, f;

  initial begin
    rst  = 1'b1;
    en   = '0;
    sync = 1'b0;
    applyStimulus(1'b0, 2'd0, 0, 0);

    // Reset state, then default 100/50 waveform on ch0
    advanceTo(2);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      expectLow(ch, 2, 2);
      expectPend(ch, 2, 2, 1'b0);
    end
    advanceTo(3);
    rst = 1'b0;
    en  = 3'b001;
    expectWave(0, 4, 100, 50, 300);
    expectLow(1, 4, 300);
    expectLow(2, 4, 300);
    advanceTo(303);

    // Clamp: N=1,H=0 written while disabled, then N=5,H=9 while running
    t = cyc;
    applyStimulus(1'b1, 2'd1, 1, 0);
    expectPend(1, t + 1, 1, 1'b0);
    advanceTo(t + 1);
    applyStimulus(1'b0, 2'd0, 0, 0);
    en = 3'b011;
    s1 = t + 2;
    expectWave(1, s1, 2, 1, 12);
    expectPend(1, s1 + 10, 1, 1'b0);
    expectPend(1, s1 + 11, 1, 1'b1);
    expectPend(1, s1 + 12, 1, 1'b0);
    expectWave(1, s1 + 12, 5, 4, 15);
    advanceTo(s1 + 10);
    applyStimulus(1'b1, 2'd1, 5, 9);
    advanceTo(s1 + 11);
    applyStimulus(1'b0, 2'd0, 0, 0);
    advanceTo(s1 + 26);
    en = 3'b000;
    p  = cyc;
    expectLow(0, p + 1, 3);
    expectLow(1, p + 1, 3);

    // Glitch-free reconfig on ch0 mid-period, then bypass on a wrap edge
    advanceTo(p + 3);
    en = 3'b001;
    c0 = p + 4;
    expectWave(0, c0, 100, 50, 100);
    expectPend(0, c0 + 29, 1, 1'b0);
    expectPend(0, c0 + 30, 70, 1'b1);
    expectPend(0, c0 + 100, 1, 1'b0);
    expectWave(0, c0 + 100, 10, 3, 40);
    advanceTo(c0 + 29);
    applyStimulus(1'b1, 2'd0, 10, 3);
    advanceTo(c0 + 30);
    applyStimulus(1'b0, 2'd0, 0, 0);
    expectPend(0, c0 + 138, 8, 1'b0);
    expectWave(0, c0 + 140, 4, 2, 16);
    advanceTo(c0 + 139);
    applyStimulus(1'b1, 2'd0, 4, 2);
    advanceTo(c0 + 140);
    applyStimulus(1'b0, 2'd0, 0, 0);
    advanceTo(c0 + 155);
    en = 3'b000;
    expectLow(0, c0 + 156, 1);

    // Sync: ch0 N=7 (coincides with its wrap), ch1 N=11 mid-period, ch2 disabled
    e = cyc;
    applyStimulus(1'b1, 2'd0, 7, 3);
    advanceTo(e + 1);
    applyStimulus(1'b1, 2'd1, 11, 5);
    advanceTo(e + 2);
    applyStimulus(1'b0, 2'd0, 0, 0);
    en = 3'b001;
    expectWave(0, e + 3, 7, 3, 28);
    expectWave(0, e + 31, 7, 3, 33);
    expectLow(1, e + 3, 4);
    expectWave(1, e + 7, 11, 5, 24);
    expectWave(1, e + 31, 11, 5, 33);
    expectLow(2, e + 3, 61);
    advanceTo(e + 6);
    en = 3'b011;
    advanceTo(e + 30);
    sync = 1'b1;
    advanceTo(e + 31);
    sync = 1'b0;
    advanceTo(e + 63);
    en = 3'b000;
    expectLow(0, e + 64, 1);
    expectLow(1, e + 64, 1);

    // Disable/re-enable, async reset discarding pending config, invalid channel write
    f = cyc;
    applyStimulus(1'b1, 2'd0, 100, 50);
    advanceTo(f + 1);
    applyStimulus(1'b0, 2'd0, 0, 0);
    en = 3'b001;
    expectWave(0, f + 2, 100, 50, 21);
    expectLow(0, f + 23, 3);
    expectWave(0, f + 26, 100, 50, 40);
    expectPend(0, f + 61, 5, 1'b1);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      expectLow(ch, f + 66, 3);
      expectPend(ch, f + 66, 3, 1'b0);
      expectPend(ch, f + 81, 2, 1'b0);
    end
    expectWave(0, f + 69, 100, 50, 40);
    expectPend(0, f + 69, 7, 1'b0);
    expectLow(2, f + 69, 17);
    expectWave(2, f + 86, 100, 50, 20);
    advanceTo(f + 22);
    en = 3'b000;
    advanceTo(f + 25);
    en = 3'b001;
    advanceTo(f + 60);
    applyStimulus(1'b1, 2'd0, 10, 5);
    advanceTo(f + 61);
    applyStimulus(1'b0, 2'd0, 0, 0);
    advanceTo(f + 66);
    #1;
    rst = 1'b1;
    advanceTo(f + 68);
    rst = 1'b0;
    advanceTo(f + 80);
    applyStimulus(1'b1, 2'd3, 4, 1);
    advanceTo(f + 81);
    applyStimulus(1'b0, 2'd0, 0, 0);
    advanceTo(f + 85);
    en = 3'b101;
    advanceTo(f + 110);

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
